// File: rtl/dll_pkg.sv
// Shared constants and types for the data-link-layer TX arbiter.
package dll_pkg;

  localparam int DLLP_LEN = 6;

  localparam logic TYPE_DLLP = 1'b0;
  localparam logic TYPE_TLP  = 1'b1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    TLP_RPL = 2'd1,
    TLP_NEW = 2'd2
  } arb_state_t;

  // Which requester owns the output register in the current cycle.
  typedef enum logic [1:0] {
    SEL_NONE = 2'd0,
    SEL_DLLP = 2'd1,
    SEL_RPL  = 2'd2,
    SEL_NEW  = 2'd3
  } src_sel_t;

endpackage

// File: rtl/dll_tx_arbiter_if.sv
// Requester and framer-side signals of the DLL TX arbiter, grouped into one bundle.
interface dll_tx_arbiter_if #(
  parameter int DATA_W = 128,
  parameter int LEN_W  = 6
);

  logic              dllp_req;
  logic [63:0]       dllp_data;
  logic              dllp_ack;

  logic              rpl_vld;
  logic [DATA_W-1:0] rpl_data;
  logic [LEN_W-1:0]  rpl_len;
  logic              rpl_end;
  logic              rpl_rdy;
  logic              rpl_active;

  logic              tlp_vld;
  logic [DATA_W-1:0] tlp_data;
  logic [LEN_W-1:0]  tlp_len;
  logic              tlp_end;
  logic              tlp_rdy;

  logic              o_vld;
  logic [DATA_W-1:0] o_data;
  logic [LEN_W-1:0]  o_len;
  logic              o_end;
  logic              o_type;
  logic              o_rdy;

  // Arbiter side.
  modport slave (
    input  dllp_req, dllp_data,
    input  rpl_vld, rpl_data, rpl_len, rpl_end, rpl_active,
    input  tlp_vld, tlp_data, tlp_len, tlp_end,
    input  o_rdy,
    output dllp_ack, rpl_rdy, tlp_rdy,
    output o_vld, o_data, o_len, o_end, o_type
  );

  // Requesters plus framer side.
  modport master (
    output dllp_req, dllp_data,
    output rpl_vld, rpl_data, rpl_len, rpl_end, rpl_active,
    output tlp_vld, tlp_data, tlp_len, tlp_end,
    output o_rdy,
    input  dllp_ack, rpl_rdy, tlp_rdy,
    input  o_vld, o_data, o_len, o_end, o_type
  );

endinterface

// File: rtl/dll_tx_out_reg.sv
// Single-entry ready/valid output register toward the physical-layer framer.
module dll_tx_out_reg #(
  parameter int DATA_W = 128,
  parameter int LEN_W  = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_vld,
  input  logic [DATA_W-1:0] in_data,
  input  logic [LEN_W-1:0]  in_len,
  input  logic              in_end,
  input  logic              in_type,
  input  logic              o_rdy,
  output logic              load,
  output logic              o_vld,
  output logic [DATA_W-1:0] o_data,
  output logic [LEN_W-1:0]  o_len,
  output logic              o_end,
  output logic              o_type
);

  logic              vld_r;
  logic [DATA_W-1:0] data_r;
  logic [LEN_W-1:0]  len_r;
  logic              end_r;
  logic              type_r;

  // Empty, or the held beat leaves this cycle.
  assign load = !vld_r | o_rdy;

  // Capture a new beat only when load is open; otherwise hold everything stable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_r  <= 1'b0;
      data_r <= {DATA_W{1'b0}};
      len_r  <= {LEN_W{1'b0}};
      end_r  <= 1'b0;
      type_r <= 1'b0;
    end else if (load) begin
      vld_r <= in_vld;
      if (in_vld) begin
        data_r <= in_data;
        len_r  <= in_len;
        end_r  <= in_end;
        type_r <= in_type;
      end
    end
  end

  assign o_vld  = vld_r;
  assign o_data = data_r;
  assign o_len  = len_r;
  assign o_end  = end_r;
  assign o_type = type_r;

endmodule

// File: rtl/dll_tx_arbiter.sv
// DLL TX scheduler: DLLP / replay / new-TLP arbitration with packet atomicity and
// a bounded DLLP run while a TLP source waits.
module dll_tx_arbiter
  import dll_pkg::*;
#(
  parameter int DATA_W       = 128,
  parameter int LEN_W        = 6,
  parameter int MAX_DLLP_RUN = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  dll_tx_arbiter_if.slave bus
);

  localparam int              CNT_W   = $clog2(MAX_DLLP_RUN + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_DLLP_RUN);

  arb_state_t        state_r;
  arb_state_t        state_nxt_s;
  logic [CNT_W-1:0]  starve_cnt_r;
  logic [CNT_W-1:0]  starve_nxt_s;
  src_sel_t          sel_s;

  logic              load_s;
  logic              tlp_wait_s;
  logic              force_s;

  logic              beat_vld_s;
  logic [DATA_W-1:0] beat_data_s;
  logic [LEN_W-1:0]  beat_len_s;
  logic              beat_end_s;
  logic              beat_type_s;

  assign tlp_wait_s = bus.rpl_vld | (bus.tlp_vld & !bus.rpl_active);
  assign force_s    = (starve_cnt_r == MAX_CNT) & tlp_wait_s;

  // Grant selection, next state and next starvation count.
  always_comb begin
    sel_s        = SEL_NONE;
    state_nxt_s  = state_r;
    starve_nxt_s = starve_cnt_r;
    if (load_s) begin
      case (state_r)
        IDLE: begin
          if (bus.dllp_req && !force_s) begin
            sel_s = SEL_DLLP;
            if (tlp_wait_s) begin
              starve_nxt_s = (starve_cnt_r == MAX_CNT) ? MAX_CNT : starve_cnt_r + 1'b1;
            end else begin
              starve_nxt_s = {CNT_W{1'b0}};
            end
          end else if (bus.rpl_vld) begin
            sel_s        = SEL_RPL;
            starve_nxt_s = {CNT_W{1'b0}};
            state_nxt_s  = bus.rpl_end ? IDLE : TLP_RPL;
          end else if (bus.tlp_vld && !bus.rpl_active) begin
            sel_s        = SEL_NEW;
            starve_nxt_s = {CNT_W{1'b0}};
            state_nxt_s  = bus.tlp_end ? IDLE : TLP_NEW;
          end else begin
            sel_s = SEL_NONE;
          end
        end
        TLP_RPL: begin
          if (bus.rpl_vld) begin
            sel_s       = SEL_RPL;
            state_nxt_s = bus.rpl_end ? IDLE : TLP_RPL;
          end else begin
            sel_s = SEL_NONE;
          end
        end
        // rpl_active is deliberately ignored here so a started TLP always completes.
        TLP_NEW: begin
          if (bus.tlp_vld) begin
            sel_s       = SEL_NEW;
            state_nxt_s = bus.tlp_end ? IDLE : TLP_NEW;
          end else begin
            sel_s = SEL_NONE;
          end
        end
        default: begin
          sel_s       = SEL_NONE;
          state_nxt_s = IDLE;
        end
      endcase
    end else begin
      sel_s = SEL_NONE;
    end
  end

  // Beat multiplexer feeding the output register.
  always_comb begin
    beat_vld_s  = 1'b0;
    beat_data_s = {DATA_W{1'b0}};
    beat_len_s  = {LEN_W{1'b0}};
    beat_end_s  = 1'b0;
    beat_type_s = TYPE_DLLP;
    case (sel_s)
      SEL_DLLP: begin
        beat_vld_s  = 1'b1;
        beat_data_s = {bus.dllp_data, {(DATA_W-64){1'b0}}};
        beat_len_s  = LEN_W'(DLLP_LEN);
        beat_end_s  = 1'b1;
        beat_type_s = TYPE_DLLP;
      end
      SEL_RPL: begin
        beat_vld_s  = 1'b1;
        beat_data_s = bus.rpl_data;
        beat_len_s  = bus.rpl_len;
        beat_end_s  = bus.rpl_end;
        beat_type_s = TYPE_TLP;
      end
      SEL_NEW: begin
        beat_vld_s  = 1'b1;
        beat_data_s = bus.tlp_data;
        beat_len_s  = bus.tlp_len;
        beat_end_s  = bus.tlp_end;
        beat_type_s = TYPE_TLP;
      end
      default: begin
        beat_vld_s = 1'b0;
      end
    endcase
  end

  assign bus.dllp_ack = (sel_s == SEL_DLLP);
  assign bus.rpl_rdy  = (sel_s == SEL_RPL);
  assign bus.tlp_rdy  = (sel_s == SEL_NEW);

  // Arbitration state and starvation counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      starve_cnt_r <= {CNT_W{1'b0}};
    end else begin
      state_r      <= state_nxt_s;
      starve_cnt_r <= starve_nxt_s;
    end
  end

  dll_tx_out_reg #(
    .DATA_W (DATA_W),
    .LEN_W  (LEN_W)
  ) u_out_reg (
    .clk     (clk),
    .rst_n   (rst_n),
    .in_vld  (beat_vld_s),
    .in_data (beat_data_s),
    .in_len  (beat_len_s),
    .in_end  (beat_end_s),
    .in_type (beat_type_s),
    .o_rdy   (bus.o_rdy),
    .load    (load_s),
    .o_vld   (bus.o_vld),
    .o_data  (bus.o_data),
    .o_len   (bus.o_len),
    .o_end   (bus.o_end),
    .o_type  (bus.o_type)
  );

endmodule

// File: doc/dll_tx_arbiter.md
Name: dll_tx_arbiter

Overview:
- Data-link-layer TX scheduler. Shares one 128-bit DLL transmit beat path between three requesters:
  - the DLLP generator (Ack/Nak/UpdateFC, single beat);
  - the replay (retry) buffer;
  - the new-TLP path from the transaction layer.
- Emits beats in the same vld/type/len/end format the RX demultiplexer consumes:
  - type = 1 means TLP; type = 0 means DLLP;
  - a DLLP sits in data[127:64] with len = 6.
- Enforces packet atomicity, fixed priority with anti-starvation, and a registered ready/valid output toward the physical-layer framer.

Parameters:
- DATA_W, 128, beat width in bits.
- LEN_W, 6, beat byte-count width.
- MAX_DLLP_RUN, 4, consecutive DLLP grants allowed while a TLP source is waiting before one TLP is forced.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- dllp_req  in  1  DLLP pending.
- dllp_data  in  64  DLLP: 32-bit body plus 16-bit CRC, left-aligned, bits [15:0] zero.
- dllp_ack  out  1  DLLP accepted this cycle.
- rpl_vld  in  1  replay beat valid.
- rpl_data  in  128  replay beat.
- rpl_len  in  6  valid bytes in beat.
- rpl_end  in  1  last beat of TLP.
- rpl_rdy  out  1  replay beat accepted.
- rpl_active  in  1  replay sequence in progress; blocks new TLPs.
- tlp_vld  in  1  new-TLP beat valid.
- tlp_data  in  128  new-TLP beat.
- tlp_len  in  6  valid bytes in beat.
- tlp_end  in  1  last beat.
- tlp_rdy  out  1  new-TLP beat accepted.
- o_vld  out  1  output beat valid.
- o_data  out  128  output beat.
- o_len  out  6  byte count.
- o_end  out  1  last beat of packet.
- o_type  out  1  1 = TLP, 0 = DLLP.
- o_rdy  in  1  downstream accepts.

Behaviour:
- Reset (asynchronous, rst_n = 0):
  - o_vld, o_data, o_len, o_end and o_type are all 0;
  - state is IDLE; starve_cnt is 0.
  - Reset mid-packet drops the packet. Sources restart from their first beat.
- Output register:
  - load = !o_vld | o_rdy.
  - A beat is captured only when load = 1. Latency is 1 cycle from acceptance to o_vld.
  - o_* are held stable while o_vld & !o_rdy.
- Acceptance handshakes:
  - dllp_ack, rpl_rdy and tlp_rdy are combinational.
  - Each is asserted only in the cycle its beat is captured; at most one is high per cycle.
- States: IDLE, TLP_RPL, TLP_NEW.
- IDLE, when load = 1, evaluates in this order:
  1. force = (starve_cnt == MAX_DLLP_RUN) & (rpl_vld | (tlp_vld & !rpl_active)).
  2. If dllp_req & !force, send the DLLP:
     - o_type = 0, o_len = 6, o_end = 1, o_data = {dllp_data, 64'b0};
     - dllp_ack = 1;
     - starve_cnt increments if a TLP source is waiting, saturating at MAX_DLLP_RUN; otherwise it clears.
  3. Else if rpl_vld, send the replay beat:
     - o_type = 1; data, len and end pass through; rpl_rdy = 1; starve_cnt clears;
     - if !rpl_end, go to TLP_RPL.
  4. Else if tlp_vld & !rpl_active, send the new-TLP beat:
     - same as step 3 using the tlp_* signals; if !tlp_end, go to TLP_NEW.
  5. Else nothing is loaded.
- TLP_RPL:
  - Only replay beats are accepted; rpl_rdy = load & rpl_vld.
  - DLLPs and new TLPs wait.
  - The beat with rpl_end = 1 returns the FSM to IDLE.
  - A gap (rpl_vld = 0) holds the state and inserts no other traffic.
- TLP_NEW:
  - Same as TLP_RPL using the tlp_* signals.
  - An rpl_active rise mid-packet does not abort the packet; the current TLP completes.
- Boundary cases:
  - A single-beat TLP (end = 1 on the first beat) never leaves IDLE.
  - rpl_vld and tlp_vld together: replay wins.
  - All three requesting with starve_cnt below the limit: the DLLP wins.
  - len passes unchanged; the arbiter performs no length arithmetic.
  - A DLLP request that arrives during a TLP is held by the requester, not dropped; dllp_req must stay high until dllp_ack.

Decomposition:
- Shared package dll_pkg:
  - DLLP_LEN = 6;
  - beat-type constants TYPE_DLLP = 0 and TYPE_TLP = 1;
  - the state enum typedef.
- One sub-module, dll_tx_out_reg: the ready/valid output register, parameterised on DATA_W and LEN_W.
- Arbitration FSM and starve counter stay in the top.

Test Plan:
- Only dllp_req, dllp_data = 64'hA1B2C3D4_1234_0000, o_rdy = 1 -> next cycle o_vld = 1, o_type = 0, o_len = 6, o_end = 1, o_data[127:64] = dllp_data; one-cycle dllp_ack.
- 3-beat new TLP (lens 16, 16, 4), dllp_req rises on beat 2 -> all 3 TLP beats go out contiguously, then the DLLP; o_end only on beat 3.
- rpl_vld and tlp_vld together, each a 1-beat TLP, rpl_active = 1 -> replay beat first; new TLP blocked until rpl_active = 0.
- dllp_req held high for 6 cycles with tlp_vld = 1 and MAX_DLLP_RUN = 4 -> 4 DLLPs, 1 TLP beat, then DLLPs resume.
- o_rdy = 0 for 3 cycles mid-packet -> o_* held stable, no rdy/ack pulses, no beat lost or duplicated.
- rst_n asserted while in TLP_RPL -> o_vld = 0 immediately; after release, state IDLE and starve_cnt = 0.
